oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/gb_pkg.sv | 21 ++
 rtl/oam_dma.sv | 154 +++++++++++++++
 tb/tb_oam_dma.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_pkg.sv
// Shared Game Boy constants and types used by the OAM DMA engine.
package gb_pkg;

   localparam logic [15:0] OAM_BASE     = 16'hFE00;
   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam int unsigned OAM_BYTES    = 160;

   typedef enum logic [2:0] {
      IDLE,
      STARTUP,
      ISSUE,
      WAIT,
      DONE
   } dma_state_t;

   // Pages 0xE0-0xFF are echo RAM; fold them back onto 0xC0-0xDF.
   function automatic logic [7:0] src_page(input logic [7:0] page);
      return (page < 8'hE0) ? page : 8'(page - 8'h20);
   endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies OAM_BYTES bytes from page<<8 into OAM at 0xFE00,
// one byte per M-cycle after a single start-up M-cycle.
module oam_dma #(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned OAM_BYTES    = gb_pkg::OAM_BYTES
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        mclock_in,
   input  logic        start_in,
   input  logic [7:0]  page_in,
   output logic [7:0]  page_out,
   output logic        active_out,
   output logic [15:0] rd_addr_out,
   output logic        rd_en_out,
   input  logic [7:0]  rd_data_in,
   output logic [15:0] wr_addr_out,
   output logic [7:0]  wr_data_out,
   output logic        wr_en_out
);

   localparam int unsigned LAT    = READ_LATENCY;
   localparam logic [7:0]  OAM_HI = gb_pkg::OAM_BASE[15:8];
   localparam logic [7:0]  OAM_LO = gb_pkg::OAM_BASE[7:0];

   logic [1:0]          rst_sync;
   logic                run;

   gb_pkg::dma_state_t  state, state_d;
   logic [7:0]          index, index_d;
   logic [7:0]          page_q, page_d;
   logic [LAT-1:0]      lat_sr, lat_d;
   logic [15:0]         rd_addr_q, rd_addr_d;
   logic [15:0]         wr_addr_q, wr_addr_d;
   logic                wr_en_q, wr_en_d;
   logic                active_q, active_d;
   logic [8:0]          idx_inc;

   // Reset release synchroniser: asserts with rst_in, releases two edges later.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run = rst_sync[1];

   // State register and registered outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= gb_pkg::IDLE;
         index     <= 8'h00;
         page_q    <= 8'h00;
         lat_sr    <= '0;
         rd_addr_q <= 16'h0000;
         wr_addr_q <= 16'h0000;
         wr_en_q   <= 1'b0;
         active_q  <= 1'b0;
      end else begin
         state     <= state_d;
         index     <= index_d;
         page_q    <= page_d;
         lat_sr    <= lat_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_en_q   <= wr_en_d;
         active_q  <= active_d;
      end
   end

   // Next-state and next-output logic; lat_sr[0] is the read strobe itself.
   always_comb begin
      state_d   = state;
      index_d   = index;
      page_d    = page_q;
      lat_d     = lat_sr << 1;
      rd_addr_d = rd_addr_q;
      wr_en_d   = lat_sr[LAT-1];
      wr_addr_d = wr_addr_q;
      idx_inc   = {1'b0, index} + 9'd1;

      // The write leaving next cycle belongs to the byte still held in index.
      if (wr_en_d) begin
         wr_addr_d = {OAM_HI, 8'(OAM_LO + index)};
      end

      case (state)
         gb_pkg::IDLE: begin
            state_d = gb_pkg::IDLE;
         end
         gb_pkg::STARTUP: begin
            if (mclock_in) begin
               state_d = gb_pkg::ISSUE;
            end
         end
         gb_pkg::ISSUE: begin
            if (mclock_in) begin
               lat_d[0]  = 1'b1;
               rd_addr_d = {gb_pkg::src_page(page_q), index};
               state_d   = gb_pkg::WAIT;
            end
         end
         gb_pkg::WAIT: begin
            // Strobes here are ignored; only the completed write advances.
            if (wr_en_q) begin
               index_d = idx_inc[7:0];
               state_d = (32'(idx_inc) < OAM_BYTES) ? gb_pkg::ISSUE : gb_pkg::DONE;
            end
         end
         gb_pkg::DONE: begin
            state_d = gb_pkg::IDLE;
         end
         default: begin
            state_d = gb_pkg::IDLE;
         end
      endcase

      // A new start overrides everything; a write already on the bus completes.
      if (start_in) begin
         page_d    = page_in;
         index_d   = 8'h00;
         lat_d     = '0;
         wr_en_d   = 1'b0;
         wr_addr_d = wr_addr_q;
         rd_addr_d = rd_addr_q;
         state_d   = gb_pkg::STARTUP;
      end

      // Hold everything cleared until reset release has been synchronised.
      if (!run) begin
         state_d   = gb_pkg::IDLE;
         index_d   = 8'h00;
         page_d    = 8'h00;
         lat_d     = '0;
         rd_addr_d = 16'h0000;
         wr_addr_d = 16'h0000;
         wr_en_d   = 1'b0;
      end

      active_d = (state_d != gb_pkg::IDLE);
   end

   assign page_out    = page_q;
   assign active_out  = active_q;
   assign rd_addr_out = rd_addr_q;
   assign rd_en_out   = lat_sr[0];
   assign wr_addr_out = wr_addr_q;
   assign wr_en_out   = wr_en_q;
   // Source data is forwarded in the write cycle; zero otherwise.
   assign wr_data_out = wr_en_q ? rd_data_in : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: latency-2 and latency-3 instances share stimulus.
module tb_oam_dma;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        mclock_in;
   logic        start_in;
   logic [7:0]  page_in;

   logic [7:0]  page2, rd_data2, wr_data2;
   logic        active2, rd_en2, wr_en2;
   logic [15:0] rd_addr2, wr_addr2;

   logic [7:0]  page3, rd_data3, wr_data3;
   logic        active3, rd_en3, wr_en3;
   logic [15:0] rd_addr3, wr_addr3;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mper  = 4;
   bit inj_en = 1'b0;
   int inj_from = 0;
   int s_cyc = 0;

   always #5 clk_in = ~clk_in;

   oam_dma #(.READ_LATENCY(2), .OAM_BYTES(160)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .mclock_in(mclock_in), .start_in(start_in),
      .page_in(page_in), .page_out(page2), .active_out(active2),
      .rd_addr_out(rd_addr2), .rd_en_out(rd_en2), .rd_data_in(rd_data2),
      .wr_addr_out(wr_addr2), .wr_data_out(wr_data2), .wr_en_out(wr_en2));

   oam_dma #(.READ_LATENCY(3), .OAM_BYTES(160)) dut3 (
      .clk_in(clk_in), .rst_in(rst_in), .mclock_in(mclock_in), .start_in(start_in),
      .page_in(page_in), .page_out(page3), .active_out(active3),
      .rd_addr_out(rd_addr3), .rd_en_out(rd_en3), .rd_data_in(rd_data3),
      .wr_addr_out(wr_addr3), .wr_data_out(wr_data3), .wr_en_out(wr_en3));

   // Source memory content: page 0xC1 holds i^0x5A, other pages are offset.
   function automatic logic [7:0] src_byte(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ 8'(a[15:8] - 8'hC1);
   endfunction

   // Source memory models with fixed read latency; 0xEE marks invalid data.
   logic [15:0] p2a [2];
   logic        p2v [2];
   logic [15:0] p3a [3];
   logic        p3v [3];
   always @(posedge clk_in) begin
      p2a[0] <= rd_addr2; p2v[0] <= rd_en2;
      p2a[1] <= p2a[0];   p2v[1] <= p2v[0];
      p3a[0] <= rd_addr3; p3v[0] <= rd_en3;
      p3a[1] <= p3a[0];   p3v[1] <= p3v[0];
      p3a[2] <= p3a[1];   p3v[2] <= p3v[1];
   end
   assign rd_data2 = p2v[1] ? src_byte(p2a[1]) : 8'hEE;
   assign rd_data3 = p3v[2] ? src_byte(p3a[2]) : 8'hEE;

   // Bus monitors, sampled mid-cycle.
   int wr_n = 0, rd_n = 0, ovl_n = 0, lat_bad = 0, act_n = 0, last_rd = 0;
   int wr3_n = 0, rd3_n = 0, ovl3_n = 0, lat3_bad = 0, last_rd3 = 0;
   logic [15:0] wr_aq[$];
   logic [7:0]  wr_dq[$];
   logic [15:0] rd_aq[$];
   int          rd_cq[$];

   always @(negedge clk_in) begin
      if (active2) act_n++;
      if (rd_en2) begin
         rd_n++; rd_aq.push_back(rd_addr2); rd_cq.push_back(cyc); last_rd = cyc;
      end
      if (wr_en2) begin
         wr_n++; wr_aq.push_back(wr_addr2); wr_dq.push_back(wr_data2);
         if (cyc - last_rd != 2) lat_bad++;
      end
      if (rd_en2 && wr_en2) ovl_n++;
      if (rd_en3) begin rd3_n++; last_rd3 = cyc; end
      if (wr_en3) begin
         wr3_n++;
         if (cyc - last_rd3 != 3) lat3_bad++;
      end
      if (rd_en3 && wr_en3) ovl3_n++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
      cyc++;
      start_in  = 1'b0;
      mclock_in = ((cyc % mper) == 0) || (inj_en && (cyc % 4) == 2 && cyc >= inj_from);
   endtask

   // Start pulse placed so that the next cycle carries an mclock strobe.
   task automatic start_aligned(input logic [7:0] p);
      int n = 0;
      do begin tick(); n++; end while ((cyc % mper) != mper - 1 && n < 64);
      start_in = 1'b1;
      page_in  = p;
      s_cyc    = cyc;
   endtask

   task automatic wait_writes(input int target, input string tag);
      int n = 0;
      while (wr_n < target && n < 2000) begin tick(); n++; end
      chk(tag, 32'(wr_n >= target), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input bit use3, input string tag);
      int   n = 0;
      logic act;
      do begin
         tick(); n++;
         act = use3 ? active3 : active2;
      end while (act && n < budget);
      chk(tag, 32'(act), 32'd0);
   endtask

   task automatic chk_zero(input string pfx);
      chk({pfx, "_page"},    32'(page2),    32'h0);
      chk({pfx, "_active"},  32'(active2),  32'h0);
      chk({pfx, "_rd_addr"}, 32'(rd_addr2), 32'h0);
      chk({pfx, "_rd_en"},   32'(rd_en2),   32'h0);
      chk({pfx, "_wr_addr"}, 32'(wr_addr2), 32'h0);
      chk({pfx, "_wr_data"}, 32'(wr_data2), 32'h0);
      chk({pfx, "_wr_en"},   32'(wr_en2),   32'h0);
   endtask

   initial begin
      int w0, r0, a0, errs, s2, r3, w3, fe32;

      rst_in = 1'b0; mclock_in = 1'b0; start_in = 1'b0; page_in = 8'h00;
      repeat (3) tick();
      chk_zero("rst");
      chk("rst_page3", 32'(page3), 32'h0);
      rst_in = 1'b1;
      repeat (4) tick();
      chk("post_rst_active", 32'(active2), 32'h0);

      // Full transfer from page 0xC1.
      w0 = wr_n; r0 = rd_n; a0 = act_n;
      start_aligned(8'hC1);
      wait_idle(800, 1'b0, "a_idle_timeout");
      chk("a_writes", 32'(wr_n - w0), 32'd160);
      chk("a_reads",  32'(rd_n - r0), 32'd160);
      chk("a_active_cycles", 32'(act_n - a0), 32'd645);
      chk("a_page", 32'(page2), 32'hC1);
      errs = 0;
      for (int i = 0; i < 160; i++) begin
         if (wr_aq[w0 + i] !== 16'(16'hFE00 + i)) errs++;
         if (wr_dq[w0 + i] !== (8'(i) ^ 8'h5A)) errs++;
      end
      chk("a_write_log", 32'(errs), 32'd0);
      chk("a_last_addr", 32'(wr_aq[w0 + 159]), 32'hFE9F);

      // Echo page 0xE3 with extra strobes injected during WAIT.
      w0 = wr_n; r0 = rd_n; a0 = act_n;
      start_aligned(8'hE3);
      inj_from = s_cyc + 6;
      inj_en   = 1'b1;
      wait_idle(800, 1'b0, "b_idle_timeout");
      inj_en   = 1'b0;
      chk("b_page", 32'(page2), 32'hE3);
      chk("b_reads",  32'(rd_n - r0), 32'd160);
      chk("b_writes", 32'(wr_n - w0), 32'd160);
      chk("b_active_cycles", 32'(act_n - a0), 32'd645);
      chk("b_first_rd", 32'(rd_aq[r0]), 32'hC300);
      chk("b_last_rd",  32'(rd_aq[r0 + 159]), 32'hC39F);
      errs = 0;
      for (int i = 0; i < 160; i++) begin
         if (rd_aq[r0 + i] !== 16'(16'hC300 + i)) errs++;
         if (wr_dq[w0 + i] !== (8'(i) ^ 8'h58)) errs++;
      end
      chk("b_log", 32'(errs), 32'd0);

      // Restart in the same cycle as the write of byte 4.
      w0 = wr_n; r0 = rd_n;
      start_aligned(8'hC1);
      repeat (24) tick();
      start_in = 1'b1; page_in = 8'h80;
      wait_idle(800, 1'b0, "c_idle_timeout");
      chk("c_writes", 32'(wr_n - w0), 32'd165);
      chk("c_reads",  32'(rd_n - r0), 32'd165);
      chk("c_wr4_addr", 32'(wr_aq[w0 + 4]), 32'hFE04);
      chk("c_wr4_data", 32'(wr_dq[w0 + 4]), 32'h5E);
      chk("c_new_addr", 32'(wr_aq[w0 + 5]), 32'hFE00);
      chk("c_new_data", 32'(wr_dq[w0 + 5]), 32'hE5);
      chk("c_page", 32'(page2), 32'h80);

      // Restart with page 0x80 after 50 writes.
      w0 = wr_n; r0 = rd_n;
      start_aligned(8'hC1);
      wait_writes(w0 + 50, "d_wait50_timeout");
      start_in = 1'b1; page_in = 8'h80;
      s2 = cyc;
      chk("d_reads_before", 32'(rd_n - r0), 32'd50);
      wait_idle(900, 1'b0, "d_idle_timeout");
      chk("d_writes", 32'(wr_n - w0), 32'd210);
      chk("d_restart_rd_addr", 32'(rd_aq[r0 + 50]), 32'h8000);
      chk("d_restart_rd_delay", 32'(rd_cq[r0 + 50] - s2), 32'd9);
      chk("d_first_new_wr", 32'(wr_aq[w0 + 50]), 32'hFE00);
      fe32 = 0;
      errs = 0;
      for (int i = 0; i < 210; i++) if (wr_aq[w0 + i] == 16'hFE32) fe32++;
      for (int i = 0; i < 160; i++) begin
         if (wr_aq[w0 + 50 + i] !== 16'(16'hFE00 + i)) errs++;
         if (wr_dq[w0 + 50 + i] !== (8'(i) ^ 8'hE5)) errs++;
      end
      chk("d_fe32_count", 32'(fe32), 32'd1);
      chk("d_new_log", 32'(errs), 32'd0);

      // Reset asserted at index 10.
      w0 = wr_n;
      start_aligned(8'hC1);
      wait_writes(w0 + 10, "e_wait10_timeout");
      rst_in = 1'b0;
      #1;
      chk_zero("e_rst");
      repeat (20) tick();
      chk("e_no_writes", 32'(wr_n - w0), 32'd10);
      rst_in = 1'b1;
      repeat (5) tick();
      chk("e_idle_active", 32'(active2), 32'h0);
      chk("e_idle_page",   32'(page2),   32'h0);
      chk("e_idle_rd_en",  32'(rd_en2),  32'h0);

      // Latency-3 instance with mclock every 8 cycles.
      mper = 8;
      w3 = wr3_n; r3 = rd3_n;
      start_aligned(8'hC1);
      wait_idle(2000, 1'b1, "f_idle_timeout");
      chk("f_writes3", 32'(wr3_n - w3), 32'd160);
      chk("f_reads3",  32'(rd3_n - r3), 32'd160);
      chk("f_lat3", 32'(lat3_bad), 32'd0);
      chk("f_ovl3", 32'(ovl3_n),   32'd0);
      chk("g_lat2", 32'(lat_bad),  32'd0);
      chk("g_ovl2", 32'(ovl_n),    32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
